// File: rtl/escolha_algoritmo.sv
// escolha_algoritmo: 4x4 grey-frame resampler (replicate/decimate/average/pass).
// Build option: define ESCOLHA_MEDIA_EN to include the 2x2 average mode.
module escolha_algoritmo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_pixel,
  input  logic [4:0] SW,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic [2:0] {
    M_IDLE,
    M_REP,
    M_DEC,
    M_AVG,
    M_PASS
  } mode_e;

  logic [4:0] sw_q;
  logic [4:0] sw_low;
  logic       sw_chg;
  mode_e      mode;

  logic [5:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       x_odd, y_odd, last_px;

`ifdef ESCOLHA_MEDIA_EN
  logic [7:0]      pair_q, pair_d;
  logic [1:0][8:0] lb_q, lb_d;
  logic [9:0]      avg_sum;
`endif

  assign sw_chg  = (SW != sw_q);
  assign x_odd   = cnt_q[0];
  assign y_odd   = cnt_q[2];
  assign last_px = (cnt_q[3:0] == 4'hF);

  // Mode from the lowest set switch bit; SW[0] wins.
  always_comb begin
    sw_low = sw_q & (~sw_q + 5'd1);
    mode   = M_IDLE;
    unique case (1'b1)
      sw_low[0]: mode = M_REP;
      sw_low[1]: mode = M_DEC;
`ifdef ESCOLHA_MEDIA_EN
      sw_low[2]: mode = M_AVG;
`else
      sw_low[2]: mode = M_IDLE;
`endif
      sw_low[3]: mode = M_PASS;
      sw_low[4]: mode = M_IDLE;
      default:   mode = M_IDLE;
    endcase
  end

  // Next-state: consume one pixel per clock until the frame is done.
  always_comb begin
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = done_q;
`ifdef ESCOLHA_MEDIA_EN
    pair_d  = pair_q;
    lb_d    = lb_q;
    avg_sum = '0;
`endif
    if (sw_chg) begin
      cnt_d  = '0;
      done_d = 1'b0;
`ifdef ESCOLHA_MEDIA_EN
      pair_d = '0;
      lb_d   = '0;
`endif
    end else if (mode == M_IDLE) begin
      cnt_d  = '0;
      out_d  = '0;
      done_d = 1'b0;
`ifdef ESCOLHA_MEDIA_EN
      pair_d = '0;
      lb_d   = '0;
`endif
    end else if (!done_q) begin
      cnt_d = cnt_q + 6'd1;
      unique case (mode)
        M_REP: begin
          out_d   = in_pixel;
          valid_d = 1'b1;
          done_d  = (cnt_q == 6'd63);
        end
        M_DEC: begin
          if (!x_odd && !y_odd) begin
            out_d   = in_pixel;
            valid_d = 1'b1;
          end
          done_d = last_px;
        end
`ifdef ESCOLHA_MEDIA_EN
        M_AVG: begin
          if (!x_odd) begin
            pair_d = in_pixel;
          end else if (!y_odd) begin
            lb_d[cnt_q[1]] = {1'b0, pair_q} + {1'b0, in_pixel};
          end else begin
            avg_sum = {1'b0, lb_q[cnt_q[1]]}
                    + {2'b0, pair_q}
                    + {2'b0, in_pixel};
            out_d   = 8'(avg_sum >> 2);
            valid_d = 1'b1;
          end
          done_d = last_px;
        end
`endif
        M_PASS: begin
          out_d   = in_pixel;
          valid_d = 1'b1;
          done_d  = last_px;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ESCOLHA_MEDIA_EN
      pair_q  <= '0;
      lb_q    <= '0;
`endif
    end else begin
      sw_q    <= SW;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef ESCOLHA_MEDIA_EN
      pair_q  <= pair_d;
      lb_q    <= lb_d;
`endif
    end
  end

  assign out_pixel = out_q;
  assign out_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_escolha_algoritmo.sv
// tb_escolha_algoritmo: directed scoreboard bench for escolha_algoritmo.
// Honours ESCOLHA_MEDIA_EN the same way as the design.
module tb_escolha_algoritmo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_pixel;
  logic [4:0] SW;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbq[$];
  logic [7:0] last_exp;
  logic [7:0] fr[16];
  logic [7:0] v;

  escolha_algoritmo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (in_pixel),
    .SW        (SW),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] pix, input bit ev,
                      input logic [7:0] epx, input bit ed, input bit idle);
    in_pixel = pix;
    if (ev) sbq.push_back(epx);
    @(posedge clk);
    #1;
    if (ev) last_exp = epx;
    else if (idle) last_exp = 8'd0;
    chk("out_valid", out_valid, ev);
    chk("done", done, ed);
    chk("out_pixel", out_pixel, last_exp);
    if (out_valid === 1'b1) begin
      chk("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) chk("sb_pixel", out_pixel, sbq.pop_front());
    end
  endtask

  task automatic sw_change(input logic [4:0] s);
    SW = s;
    @(posedge clk);
    #1;
    chk("chg_valid", out_valid, 0);
    chk("chg_done", done, 0);
    chk("chg_pixel", out_pixel, last_exp);
  endtask

  task automatic avg_frame(input logic [7:0] f[16]);
    int e;
    for (int i = 0; i < 16; i++) begin
      e = 0;
      if ((i % 2 == 1) && ((i / 4) % 2 == 1))
        e = (int'(f[i-5]) + int'(f[i-4]) + int'(f[i-1]) + int'(f[i])) / 4;
      step(f[i], (i % 2 == 1) && ((i / 4) % 2 == 1), 8'(e), i == 15, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    SW = 5'b00000;
    in_pixel = 8'd0;
    last_exp = 8'd0;
    #12;
    chk("rst_pixel", out_pixel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);

    SW = 5'b00001;
    @(negedge clk);
    rst_n = 1'b1;
    sw_change(5'b00001);
    for (int k = 0; k < 64; k++) begin
      v = 8'(((k / 8) / 2) * 4 + (k % 8) / 2);
      step(v, 1, v, k == 63, 0);
    end
    step(8'hAA, 0, 0, 1, 0);
    step(8'hAB, 0, 0, 1, 0);

    sw_change(5'b00010);
    for (int p = 0; p < 16; p++)
      step(8'(p), (p % 2 == 0) && ((p / 4) % 2 == 0), 8'(p), p == 15, 0);
    step(8'h55, 0, 0, 1, 0);

    sw_change(5'b00100);
`ifdef ESCOLHA_MEDIA_EN
    for (int i = 0; i < 16; i++) fr[i] = 8'(i);
    avg_frame(fr);
    step(8'h11, 0, 0, 1, 0);
    sw_change(5'b10000);
    step(8'h22, 0, 0, 0, 1);
    sw_change(5'b00100);
    for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(0, 255));
    fr[0] = 8'd255; fr[1] = 8'd255; fr[4] = 8'd255; fr[5] = 8'd255;
    avg_frame(fr);
`else
    for (int p = 0; p < 16; p++) step(8'(p), 0, 0, 0, 1);
`endif

    sw_change(5'b01000);
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 255));
      step(v, 1, v, i == 15, 0);
    end
    step(8'h77, 0, 0, 1, 0);

    sw_change(5'b00011);
    for (int i = 0; i < 5; i++) step(8'(100 + i), 1, 8'(100 + i), 0, 0);
    sw_change(5'b10000);
    for (int i = 0; i < 4; i++) step(8'($urandom_range(1, 255)), 0, 0, 0, 1);

    sw_change(5'b00001);
    for (int k = 0; k < 20; k++) step(8'(k + 1), 1, 8'(k + 1), 0, 0);
    sw_change(5'b00010);
    for (int p = 0; p < 16; p++)
      step(8'(p + 32), (p % 2 == 0) && ((p / 4) % 2 == 0), 8'(p + 32),
           p == 15, 0);

    sw_change(5'b01000);
    for (int i = 0; i < 5; i++) step(8'(200 + i), 1, 8'(200 + i), 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    last_exp = 8'd0;
    chk("arst_pixel", out_pixel, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sw_change(5'b01000);
    for (int i = 0; i < 16; i++) step(8'(i + 60), 1, 8'(i + 60), i == 15, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/escolha_algoritmo.md
ESCOLHA_ALGORITMO -- requirements
Module: escolha_algoritmo

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: in_pixel  input  8  unsigned grey pixel, one per clock, raster order.
REQ-004 SHALL have: SW  input  5  algorithm select switches.
REQ-005 SHALL have: out_pixel  output  8  registered result pixel.
REQ-006 SHALL have: out_valid  output  1  high for one clock per meaningful out_pixel.
REQ-007 SHALL have: done  output  1  sticky frame-complete flag.
REQ-008 SHALL use one clock, clk; reset is asynchronous and active-low (rst_n).

Function
REQ-009 SHALL decode mode by lowest set bit, SW[0] highest priority:
- SW[0] replication
- SW[1] decimation
- SW[2] average
- SW[3] passthrough
- SW[4] alone or SW==0: idle
REQ-010 Source frame SHALL be 4x4; internal x,y counters (2 bits each) track raster position; one input pixel consumed per clock while active and done=0.
REQ-011 Replication: upstream presents the pre-sequenced 8x8 stream (each pixel twice, each row twice); out_pixel SHALL equal in_pixel of previous clock, out_valid=1 each of 64 output clocks.
REQ-012 Replication: done SHALL rise on the same edge that registers the 64th output pixel.
REQ-013 Decimation: output SHALL be the pixel at even x and even y, registered next clock with out_valid=1; 4 outputs per frame.
REQ-014 Average: output SHALL be floor((a+b+c+d)/4) of each 2x2 block.
- 10-bit sum, 2-entry line buffer for the previous row pair sums.
- emitted the clock after the pixel at odd x, odd y.
- 4 outputs per frame.
REQ-015 Passthrough: out_pixel = previous-clock in_pixel, 16 outputs.
REQ-016 Decimation, average and passthrough: done SHALL rise with the final output of a 16-pixel frame.
REQ-017 After done=1, out_pixel SHALL hold its last value, out_valid=0, and counters SHALL freeze.
REQ-018 Idle mode: out_pixel=0, out_valid=0, done=0, counters held at 0.
REQ-019 SW SHALL be registered once. Any change of the registered SW (including mid-frame) SHALL clear counters, line buffer, out_valid and done on the next edge; the new frame starts the following clock.
REQ-020 x wraps 3→0 with y increment; y=3,x=3 is the last source pixel; no wrap beyond frame.

Reset
REQ-021 rst_n=0 SHALL immediately force out_pixel=0, out_valid=0, done=0, counters, line buffer and registered SW to 0.
REQ-022 First frame SHALL start on the first clock after rst_n deasserts with a non-idle mode; reset mid-frame aborts the frame.

Configuration
REQ-023 Macro ESCOLHA_MEDIA_EN defined: average mode (SW[2]) SHALL be compiled in.
REQ-024 Macro ESCOLHA_MEDIA_EN undefined: no adder or line buffer; SW[2] as lowest set bit SHALL behave as idle.

Verification
REQ-025 SW=00001, 8x8 replicated stream of source 0..15 -> out_pixel trails in_pixel by 1 clock; done=1 exactly with the 64th output; out_pixel=15 held.
REQ-026 SW=00010, raster 0..15 -> out_valid pulses with 0,2,8,10; done with value 10.
REQ-027 SW=00100 (macro defined), raster 0..15 -> outputs 2,4,10,12; done after 12. Macro undefined -> out_pixel stays 0, done stays 0.
REQ-028 SW=00011 -> replication wins (priority). SW=10000 -> idle outputs all 0.
REQ-029 SW changed 00001->00010 at output 20 -> done and counters cleared, decimation frame restarts, 4 outputs.
REQ-030 rst_n pulsed low mid-frame asynchronously -> outputs 0 within the low phase, no clock needed; frame restarts after release.
